// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: state encodings and default width.
package div_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step; borrow=0 means the quotient bit is 1.
module div_trial_sub #(
   parameter int W = 9
) (
   input  logic [W-1:0] minuend,
   input  logic [W-1:0] subtrahend,
   output logic [W-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | iterating, one quotient bit per cycle, busy=1
//   DONE  | results just updated, done=1 for this cycle; start accepted here too
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem_w;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             unused_diff_msb;

   // acc starts as the dividend and fills with quotient bits from the LSB side
   assign shifted = {rem_w, acc[WIDTH-1]};

   div_trial_sub #(.W(WIDTH + 1)) u_trial (
      .minuend    (shifted),
      .subtrahend ({1'b0, dvs}),
      .diff       (diff),
      .borrow     (borrow)
   );

   // A kept difference is always below the divisor, so its top bit is zero.
   assign unused_diff_msb = diff[WIDTH];
   assign rem_nxt = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign q_nxt   = {acc[WIDTH-2:0], ~borrow};

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         acc       <= '0;
         dvs       <= '0;
         rem_w     <= '0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (divisor == '0) begin
                     state     <= ST_DONE;
                     cnt       <= '0;
                     quotient  <= '1;
                     remainder <= dividend;
                     dbz       <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     cnt   <= CW'(WIDTH);
                     acc   <= dividend;
                     dvs   <= divisor;
                     rem_w <= '0;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc   <= q_nxt;
               rem_w <= rem_nxt;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= ST_DONE;
                  quotient  <= q_nxt;
                  remainder <= rem_nxt;
                  dbz       <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
